// File: rtl/prbs_gen_chk_if.sv
// Pin bundle for the PRBS-7 loopback block: error-injection control in, per-lane error flags out.
// No valid/ready handshake: INJ_ERR is level-sampled on every rising CLK, and each ERR_DETECT_* is valid every cycle.
interface prbs_gen_chk_if;
    logic INJ_ERR;
    logic ERR_DETECT_8;
    logic ERR_DETECT_9;

    modport master (output INJ_ERR, input ERR_DETECT_8, input ERR_DETECT_9);
    modport slave  (input INJ_ERR, output ERR_DETECT_8, output ERR_DETECT_9);
endinterface

// File: rtl/prbs_gen_chk_top.sv
// PRBS-7 (x^7 + x^6 + 1) loopback tester: two parallel lanes (8 and 9 bits), each with
// a generator, a transmit register and a self-synchronising checker.
module prbs_lane #(
    parameter int W           = 8,
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 6,
    parameter logic [POLY_LENGTH-1:0] INIT_SEED = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inj_err,
    input  logic         chk_en,
    input  logic         err_en,
    output logic [W-1:0] tx_word,
    output logic         err_detect
);
    localparam int L = POLY_LENGTH;

    logic [L-1:0]   gen_state;
    logic [L-1:0]   hist;
    logic [W+L-1:0] gen_ext;
    logic [W+L-1:0] chk_ext;
    logic [W-1:0]   err_vec;

    // gen_state holds the next L serial bits; extend by W bits to get this word plus the next state.
    always_comb begin
        gen_ext = '0;
        gen_ext[L-1:0] = gen_state;
        for (int i = L; i < W + L; i++) begin
            gen_ext[i] = gen_ext[i-POLY_TAP] ^ gen_ext[i-L];
        end
    end

    // hist sits below the received word so every rx bit can be predicted from the L bits before it.
    always_comb begin
        chk_ext = {tx_word, hist};
        err_vec = '0;
        for (int n = 0; n < W; n++) begin
            err_vec[n] = chk_ext[n+L] ^ chk_ext[n+L-POLY_TAP] ^ chk_ext[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_state  <= INIT_SEED;
            tx_word    <= '0;
            hist       <= '0;
            err_detect <= 1'b0;
        end else begin
            gen_state <= gen_ext[W+L-1:W];
            tx_word   <= gen_ext[W-1:0] ^ {{(W-1){1'b0}}, inj_err};
            if (chk_en) begin
                hist       <= tx_word[W-1:W-L];
                err_detect <= err_en & (|err_vec);
            end else begin
                err_detect <= 1'b0;
            end
        end
    end
endmodule

module prbs_gen_chk_top #(
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 6,
    parameter int NBITS_A     = 8,
    parameter int NBITS_B     = 9,
    parameter logic [POLY_LENGTH-1:0] INIT_SEED = 7'h7F
) (
    input  logic           CLK,
    input  logic           RST,
    prbs_gen_chk_if.slave  bus
);
    // IDLE: tx register still holds its reset zero. PRIME: first real word arrives and
    // only seeds the checker history. RUN: every word is checked.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } lane_state_e;

    lane_state_e         state;
    lane_state_e         state_next;
    logic                chk_en;
    logic                err_en;
    logic [NBITS_A-1:0]  tx_word_a;
    logic [NBITS_B-1:0]  tx_word_b;
    logic                err_a;
    logic                err_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        chk_en     = 1'b0;
        err_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_PRIME;
            end
            ST_PRIME: begin
                chk_en     = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                chk_en = 1'b1;
                err_en = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    prbs_lane #(
        .W(NBITS_A), .POLY_LENGTH(POLY_LENGTH), .POLY_TAP(POLY_TAP), .INIT_SEED(INIT_SEED)
    ) u_lane_a (
        .clk(CLK), .rst(RST), .inj_err(bus.INJ_ERR), .chk_en(chk_en), .err_en(err_en),
        .tx_word(tx_word_a), .err_detect(err_a)
    );

    prbs_lane #(
        .W(NBITS_B), .POLY_LENGTH(POLY_LENGTH), .POLY_TAP(POLY_TAP), .INIT_SEED(INIT_SEED)
    ) u_lane_b (
        .clk(CLK), .rst(RST), .inj_err(bus.INJ_ERR), .chk_en(chk_en), .err_en(err_en),
        .tx_word(tx_word_b), .err_detect(err_b)
    );

    assign bus.ERR_DETECT_8 = err_a;
    assign bus.ERR_DETECT_9 = err_b;
endmodule

// File: tb/tb_prbs_gen_chk_top.sv
// Directed bench for prbs_gen_chk_top: reset values, first words, quiet run, periodicity,
// single and multi-cycle injection, and reset in the middle of injection.
module tb_prbs_gen_chk_top;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    prbs_gen_chk_if bus ();

    prbs_gen_chk_top dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int           checks = 0;
    int           errors = 0;
    int           widx   = 0;
    logic [126:0] s127;

    // Serial reference: one full 127-bit period of s[n] = s[n-6] ^ s[n-7], seeded with seven ones.
    function automatic logic [8:0] ref_word(input int w, input int k);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = s127[(k * w + i) % 127];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        widx++;
    endtask

    task automatic chk_errs(input string tag, input logic e);
        chk({tag, "_err8"}, 32'(bus.ERR_DETECT_8), 32'(e));
        chk({tag, "_err9"}, 32'(bus.ERR_DETECT_9), 32'(e));
    endtask

    task automatic chk_tx(input string tag, input logic flip);
        logic [8:0] ra;
        logic [8:0] rb;
        ra = ref_word(8, widx) ^ {8'd0, flip};
        rb = ref_word(9, widx) ^ {8'd0, flip};
        chk({tag, "_tx_a"}, 32'(dut.tx_word_a), 32'(ra[7:0]));
        chk({tag, "_tx_b"}, 32'(dut.tx_word_b), 32'(rb));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s127 = '0;
        for (int n = 0; n < 7; n++) s127[n] = 1'b1;
        for (int n = 7; n < 127; n++) s127[n] = s127[n-6] ^ s127[n-7];

        // Reset state
        bus.INJ_ERR = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        tick();
        tick();
        chk_errs("reset", 1'b0);
        chk("reset_tx_a", 32'(dut.tx_word_a), 32'h0);
        chk("reset_tx_b", 32'(dut.tx_word_b), 32'h0);

        // First words, hand-computed
        RST = 1'b0;
        widx = -1;
        tick();
        chk("word0_a", 32'(dut.tx_word_a), 32'h7F);
        chk("word0_b", 32'(dut.tx_word_b), 32'h07F);
        chk_errs("word0", 1'b0);
        tick();
        chk("word1_a", 32'(dut.tx_word_a), 32'h20);
        chk("word1_b", 32'(dut.tx_word_b), 32'h010);
        chk_errs("word1", 1'b0);

        // 1000 clean cycles; word 127 wraps back to word 0 on both lanes
        for (int c = 0; c < 1000; c++) begin
            tick();
            chk_tx("quiet", 1'b0);
            chk_errs("quiet", 1'b0);
            if (widx == 127) begin
                chk("period_a", 32'(dut.tx_word_a), 32'h7F);
                chk("period_b", 32'(dut.tx_word_b), 32'h07F);
            end
        end

        // INJ_ERR held for three edges -> three error cycles, one edge later
        bus.INJ_ERR = 1'b1;
        tick(); chk_tx("inj3_e0", 1'b1); chk_errs("inj3_e0", 1'b0);
        tick(); chk_tx("inj3_e1", 1'b1); chk_errs("inj3_e1", 1'b1);
        tick(); chk_tx("inj3_e2", 1'b1); chk_errs("inj3_e2", 1'b1);
        bus.INJ_ERR = 1'b0;
        tick(); chk_tx("inj3_e3", 1'b0); chk_errs("inj3_e3", 1'b1);
        tick(); chk_tx("inj3_e4", 1'b0); chk_errs("inj3_e4", 1'b0);
        tick(); chk_errs("inj3_e5", 1'b0);

        // Reset while an injected error is in flight and INJ_ERR keeps toggling
        bus.INJ_ERR = 1'b1;
        tick(); chk_tx("rstmid_pre", 1'b1); chk_errs("rstmid_pre", 1'b0);
        RST = 1'b1;
        bus.INJ_ERR = 1'b0;
        tick(); chk_errs("rstmid_r0", 1'b0); chk("rstmid_r0_tx_a", 32'(dut.tx_word_a), 32'h0);
        bus.INJ_ERR = 1'b1;
        tick(); chk_errs("rstmid_r1", 1'b0); chk("rstmid_r1_tx_b", 32'(dut.tx_word_b), 32'h0);
        bus.INJ_ERR = 1'b0;
        tick(); chk_errs("rstmid_r2", 1'b0);
        bus.INJ_ERR = 1'b1;
        tick(); chk_errs("rstmid_r3", 1'b0); chk("rstmid_r3_tx_a", 32'(dut.tx_word_a), 32'h0);
        RST = 1'b0;
        bus.INJ_ERR = 1'b0;
        widx = -1;
        while (widx < 49) begin
            tick();
            chk_tx("post_rst", 1'b0);
            chk_errs("post_rst", 1'b0);
        end

        // Single-cycle injection into word 50 -> exactly one error cycle on both lanes
        bus.INJ_ERR = 1'b1;
        tick(); chk_tx("inj1_e0", 1'b1); chk_errs("inj1_e0", 1'b0);
        bus.INJ_ERR = 1'b0;
        tick(); chk_tx("inj1_e1", 1'b0); chk_errs("inj1_e1", 1'b1);
        tick(); chk_tx("inj1_e2", 1'b0); chk_errs("inj1_e2", 1'b0);
        tick(); chk_errs("inj1_e3", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
